// File: rtl/ibex_pkg.sv
// Shared sleep-controller types: FSM state encoding and wake-cause codes.
// No ports; imported by ibex_sleep_ctrl and the bench.
package ibex_pkg;

    typedef enum logic [1:0] {
        SLP_RUN,
        SLP_IDLE,
        SLP_SLEEP,
        SLP_WAKE
    } sleep_state_e;

    localparam int WAKE_CAUSE_NONE = 0;
    localparam int WAKE_CAUSE_DBG  = 1;
    localparam int WAKE_CAUSE_NMI  = 2;
    localparam int WAKE_CAUSE_IRQ0 = 3;

endpackage

// File: rtl/ibex_sat_counter.sv
// Saturating up-counter with clear priority over increment.
// Ports: clk_i, rst_i (sync, active-high), inc_i, clr_i, cnt_o [Width-1:0].
module ibex_sat_counter #(
    parameter int Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [Width-1:0] cnt_o
);

    logic [Width-1:0] cnt_q;
    logic             at_max;

    assign at_max = (cnt_q == {Width{1'b1}});

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && !at_max) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/ibex_sleep_ctrl.sv
// Sleep/wake controller: hysteresis-filtered entry, warm-up exit, wake cause
// capture and a saturating sleep-cycle counter driving the core clock gate.
// Ports: clk_i, rst_i (sync, active-high), test_en_i, core_busy_i,
//   sleep_allow_i, irq_i/irq_en_i [NumIrq], irq_nm_i, debug_req_i,
//   sleep_cnt_clr_i -> clk_en_o, core_sleep_o, wake_valid_o,
//   wake_cause_o [CauseW], sleep_cnt_o [32].
module ibex_sleep_ctrl
    import ibex_pkg::*;
#(
    parameter  int NumIrq   = 18,
    parameter  int IdleHyst = 4,
    parameter  int WakeLat  = 2,
    localparam int CauseW   = $clog2(NumIrq + 3)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              test_en_i,
    input  logic              core_busy_i,
    input  logic              sleep_allow_i,
    input  logic [NumIrq-1:0] irq_i,
    input  logic [NumIrq-1:0] irq_en_i,
    input  logic              irq_nm_i,
    input  logic              debug_req_i,
    input  logic              sleep_cnt_clr_i,
    output logic              clk_en_o,
    output logic              core_sleep_o,
    output logic              wake_valid_o,
    output logic [CauseW-1:0] wake_cause_o,
    output logic [31:0]       sleep_cnt_o
);

    if (NumIrq < 1 || NumIrq > 29) begin : g_bad_num_irq
        $error("NumIrq must be in 1..29");
    end
    if (IdleHyst < 1 || IdleHyst > 255) begin : g_bad_idle_hyst
        $error("IdleHyst must be in 1..255");
    end
    if (WakeLat < 1 || WakeLat > 255) begin : g_bad_wake_lat
        $error("WakeLat must be in 1..255");
    end

    localparam logic [7:0] HystLast = 8'(IdleHyst - 1);
    localparam logic [7:0] WakeLast = 8'(WakeLat - 1);

    sleep_state_e      state_q, state_d;
    // Shared by IDLE hysteresis and WAKE warm-up; never live together.
    logic [7:0]        cnt_q, cnt_d;
    logic [CauseW-1:0] cause_q, cause_d;
    logic [CauseW-1:0] cause_now;
    logic              wake_valid_q, wake_valid_d;
    logic [NumIrq-1:0] irq_act;
    logic              wake;
    logic              idle;
    logic              in_sleep;

    assign irq_act = irq_i & irq_en_i;
    assign wake    = irq_nm_i | debug_req_i | (|irq_act);
    assign idle    = !core_busy_i & sleep_allow_i & !wake;

    // Downward scan so the lowest-index enabled irq wins.
    always_comb begin
        cause_now = CauseW'(WAKE_CAUSE_NONE);
        for (int k = NumIrq - 1; k >= 0; k--) begin
            if (irq_act[k]) begin
                cause_now = CauseW'(WAKE_CAUSE_IRQ0 + k);
            end
        end
        if (irq_nm_i) begin
            cause_now = CauseW'(WAKE_CAUSE_NMI);
        end
        if (debug_req_i) begin
            cause_now = CauseW'(WAKE_CAUSE_DBG);
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cause_d      = cause_q;
        wake_valid_d = 1'b0;
        unique case (state_q)
            SLP_RUN: begin
                if (idle) begin
                    state_d = SLP_IDLE;
                    cnt_d   = '0;
                end
            end
            SLP_IDLE: begin
                if (!idle) begin
                    state_d = SLP_RUN;
                end else if (cnt_q == HystLast) begin
                    state_d = SLP_SLEEP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            SLP_SLEEP: begin
                if (wake || core_busy_i || !sleep_allow_i) begin
                    state_d      = SLP_WAKE;
                    cnt_d        = '0;
                    cause_d      = cause_now;
                    wake_valid_d = 1'b1;
                end
            end
            SLP_WAKE: begin
                if (cnt_q == WakeLast) begin
                    state_d = SLP_RUN;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = SLP_RUN;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= SLP_RUN;
            cnt_q        <= '0;
            cause_q      <= '0;
            wake_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cause_q      <= cause_d;
            wake_valid_q <= wake_valid_d;
        end
    end

    assign in_sleep = (state_q == SLP_SLEEP);

    ibex_sat_counter #(
        .Width (32)
    ) u_sleep_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (in_sleep),
        .clr_i (sleep_cnt_clr_i),
        .cnt_o (sleep_cnt_o)
    );

    // Combinational so a wake reopens the gate in the same cycle; reset
    // also opens it so the gated domain sees reset edges.
    assign clk_en_o     = !in_sleep | wake | test_en_i | rst_i;
    assign core_sleep_o = in_sleep;
    assign wake_valid_o = wake_valid_q;
    assign wake_cause_o = cause_q;

endmodule

// File: tb/tb_ibex_sleep_ctrl.sv
// Self-checking bench for ibex_sleep_ctrl; wake causes go through a queue
// filled when wake stimulus is driven and drained on each wake_valid_o pulse.
module tb_ibex_sleep_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        test_en;
    logic        busy;
    logic        allow;
    logic [17:0] irq;
    logic [17:0] irq_en;
    logic        nmi;
    logic        dbg;
    logic        cnt_clr;
    logic        clk_en;
    logic        core_sleep;
    logic        wake_valid;
    logic [4:0]  wake_cause;
    logic [31:0] sleep_cnt;

    logic        sat_inc;
    logic        sat_clr;
    logic [3:0]  sat_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    ibex_sleep_ctrl dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .test_en_i       (test_en),
        .core_busy_i     (busy),
        .sleep_allow_i   (allow),
        .irq_i           (irq),
        .irq_en_i        (irq_en),
        .irq_nm_i        (nmi),
        .debug_req_i     (dbg),
        .sleep_cnt_clr_i (cnt_clr),
        .clk_en_o        (clk_en),
        .core_sleep_o    (core_sleep),
        .wake_valid_o    (wake_valid),
        .wake_cause_o    (wake_cause),
        .sleep_cnt_o     (sleep_cnt)
    );

    ibex_sat_counter #(
        .Width (4)
    ) u_sat (
        .clk_i (clk),
        .rst_i (rst),
        .inc_i (sat_inc),
        .clr_i (sat_clr),
        .cnt_o (sat_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_sleep();
        for (int i = 0; i < 40 && !core_sleep; i++) begin
            step();
        end
        chk("sleep_reached", 32'(core_sleep), 1);
    endtask

    always @(negedge clk) begin
        if (!rst && wake_valid) begin
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                chk("wake_cause", 32'(wake_cause), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        rst = 1; test_en = 0; busy = 1; allow = 0;
        irq = '0; irq_en = '0; nmi = 0; dbg = 0; cnt_clr = 0;
        sat_inc = 0; sat_clr = 0;
        step();
        step();
        chk("rst_clk_en", 32'(clk_en), 1);
        chk("rst_sleep", 32'(core_sleep), 0);
        chk("rst_wvalid", 32'(wake_valid), 0);
        chk("rst_cause", 32'(wake_cause), 0);
        chk("rst_cnt", sleep_cnt, 0);

        // Sleep entry: 5th edge after idle first sampled.
        rst = 0; busy = 0; allow = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("entry_idle_sleep", 32'(core_sleep), 0);
            chk("entry_idle_clken", 32'(clk_en), 1);
        end
        step();
        chk("entry_sleep", 32'(core_sleep), 1);
        chk("entry_clken", 32'(clk_en), 0);
        chk("entry_cnt0", sleep_cnt, 0);

        // Sleep counter and clear.
        for (int i = 0; i < 10; i++) step();
        chk("cnt10", sleep_cnt, 10);
        cnt_clr = 1;
        step();
        chk("cnt_clr", sleep_cnt, 0);
        cnt_clr = 0;
        step();
        chk("cnt_after_clr", sleep_cnt, 1);

        // Masked then unmasked irq 5.
        irq[5] = 1;
        #1;
        chk("masked_clken", 32'(clk_en), 0);
        step();
        chk("masked_sleep", 32'(core_sleep), 1);
        irq_en[5] = 1;
        exp_q.push_back(8);
        #1;
        chk("unmask_clken", 32'(clk_en), 1);
        step();
        chk("wake_pulse", 32'(wake_valid), 1);
        chk("wake_sleep0", 32'(core_sleep), 0);
        irq = '0; irq_en = '0;
        step();
        chk("pulse_once", 32'(wake_valid), 0);
        chk("cause_hold", 32'(wake_cause), 8);
        // 2 warm-up edges, then RUN -> IDLE -> 4 hysteresis edges.
        for (int i = 0; i < 5; i++) step();
        chk("relat_awake", 32'(core_sleep), 0);
        step();
        chk("relat_sleep", 32'(core_sleep), 1);

        // Priority: debug over NMI over irq.
        dbg = 1; nmi = 1; irq[0] = 1; irq_en[0] = 1;
        exp_q.push_back(1);
        step();
        dbg = 0; nmi = 0; irq = '0; irq_en = '0;
        wait_sleep();
        nmi = 1; irq[0] = 1; irq_en[0] = 1;
        exp_q.push_back(2);
        step();
        nmi = 0; irq = '0; irq_en = '0;
        wait_sleep();
        irq[1] = 1; irq[3] = 1; irq[7] = 1;
        irq_en[3] = 1; irq_en[7] = 1;
        exp_q.push_back(6);
        step();
        irq = '0; irq_en = '0;
        wait_sleep();

        // Exit by permission withdrawal.
        allow = 0;
        exp_q.push_back(0);
        step();
        chk("allow_exit", 32'(core_sleep), 0);
        step();
        allow = 1;
        wait_sleep();

        // Exit by busy, then the glitch test from RUN.
        busy = 1;
        exp_q.push_back(0);
        step();
        for (int i = 0; i < 3; i++) step();
        busy = 0;
        for (int i = 0; i < 3; i++) step();
        allow = 0;
        step();
        allow = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("glitch_awake", 32'(core_sleep), 0);
        end
        step();
        chk("glitch_sleep", 32'(core_sleep), 1);

        // A held wake in RUN blocks idle.
        irq[2] = 1; irq_en[2] = 1;
        exp_q.push_back(5);
        step();
        for (int i = 0; i < 8; i++) step();
        chk("wake_blocks_idle", 32'(core_sleep), 0);
        chk("wake_blocks_clken", 32'(clk_en), 1);
        irq = '0; irq_en = '0;
        wait_sleep();

        // test_en opens the gate without waking.
        test_en = 1;
        #1;
        chk("test_en_clken", 32'(clk_en), 1);
        chk("test_en_sleep", 32'(core_sleep), 1);
        test_en = 0;
        #1;
        chk("test_en_off", 32'(clk_en), 0);
        step();
        step();

        // Reset while asleep.
        rst = 1;
        #1;
        chk("rst_sleep_clken", 32'(clk_en), 1);
        step();
        chk("rst2_sleep", 32'(core_sleep), 0);
        chk("rst2_cnt", sleep_cnt, 0);
        chk("rst2_cause", 32'(wake_cause), 0);
        chk("rst2_wvalid", 32'(wake_valid), 0);
        rst = 0;

        // Saturation on a narrow instance of the same counter.
        sat_clr = 1;
        step();
        chk("sat_clr0", 32'(sat_cnt), 0);
        sat_clr = 0; sat_inc = 1;
        for (int i = 0; i < 14; i++) step();
        chk("sat_14", 32'(sat_cnt), 14);
        for (int i = 0; i < 5; i++) step();
        chk("sat_hold", 32'(sat_cnt), 15);
        sat_clr = 1;
        step();
        chk("sat_clr_prio", 32'(sat_cnt), 0);
        sat_clr = 0; sat_inc = 0;

        step();
        chk("sb_empty", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ibex_sleep_ctrl.md
# ibex_sleep_ctrl

Parametrised sleep/wake controller for the core clock domain, replacing the single busy-flop clock-enable with a hysteresis-filtered FSM. Sits between the core (busy, sleep-permit), the interrupt/debug sources, and the core clock gate. Adds:
- a configurable number of maskable wake sources,
- idle hysteresis and a wake warm-up window,
- wake-cause capture and a saturating sleep-cycle counter.

## Interface
Parameters:
- NumIrq, 18, number of maskable wake sources (sw, timer, ext, 15 fast); range 1..29
- IdleHyst, 4, idle cycles required before sleeping; range 1..255
- WakeLat, 2, warm-up cycles after wake before RUN; range 1..255
- CauseW, $clog2(NumIrq+3), wake-cause code width (derived, not overridable)

Ports:
- clk_i  in  1  clock; the single clock
- rst_i  in  1  synchronous, active-high reset
- test_en_i  in  1  forces clk_en_o high
- core_busy_i  in  1  core is doing work
- sleep_allow_i  in  1  software permits sleep (e.g. WFI retired)
- irq_i  in  NumIrq  level interrupt requests
- irq_en_i  in  NumIrq  per-source wake enable
- irq_nm_i  in  1  non-maskable interrupt
- debug_req_i  in  1  debug request
- sleep_cnt_clr_i  in  1  clears sleep counter
- clk_en_o  out  1  enable to core clock gate
- core_sleep_o  out  1  core is asleep
- wake_valid_o  out  1  one-cycle pulse on wake
- wake_cause_o  out  CauseW  cause of last wake
- sleep_cnt_o  out  32  total cycles spent in SLEEP, saturating

## Operation
- States: RUN, IDLE, SLEEP, WAKE. Reset state is RUN.
- wake = irq_nm_i | debug_req_i | |(irq_i & irq_en_i).
- idle = !core_busy_i & sleep_allow_i & !wake.
- RUN: if idle, go to IDLE and set hcnt=0.
- IDLE:
  - if !idle, go to RUN;
  - else if hcnt==IdleHyst-1, go to SLEEP;
  - else hcnt++.
- SLEEP: if wake | core_busy_i | !sleep_allow_i, go to WAKE, set wcnt=0, and latch the cause.
- WAKE: if wcnt==WakeLat-1, go to RUN; else wcnt++. Wake inputs are ignored in WAKE; no re-entry to IDLE before RUN.
- Cause codes, in priority order:
  - 1 debug;
  - 2 NMI;
  - 3+k for the lowest-index enabled irq k;
  - 0 when the exit is due to core_busy_i or !sleep_allow_i only.
- wake_cause_o holds its value until the next SLEEP exit.
- Sleep counter increments on every cycle the state is SLEEP and saturates at 32'hFFFF_FFFF. sleep_cnt_clr_i has priority over increment in the same cycle.

## Timing
- Reset values: clk_en_o=1, core_sleep_o=0, wake_valid_o=0, wake_cause_o=0, sleep_cnt_o=0; hcnt=wcnt=0.
- clk_en_o = (state!=SLEEP) | wake | test_en_i | rst_i. This is combinational, so wake has zero latency to the clock enable. While reset is asserted, clk_en_o is forced high so the gated domain receives reset edges.
- core_sleep_o = (state==SLEEP). It is registered state only, with no combinational path from inputs.
- Sleep entry: idle sampled high from edge t continuously gives IDLE for cycles t+1..t+IdleHyst and SLEEP from t+IdleHyst+1. A single non-idle cycle inside IDLE restarts the sequence via RUN.
- Wake exit: wake sampled at edge t in SLEEP gives WAKE for t+1..t+WakeLat and RUN at t+WakeLat+1.
- wake_valid_o is high exactly in cycle t+1. wake_cause_o is valid from t+1.
- Simultaneous idle entry and wake in RUN/IDLE: wake blocks idle, so the FSM stays in or returns to RUN.
- Reset mid-SLEEP or mid-WAKE: the next edge gives RUN and clears all counters, including sleep_cnt_o.

## Structure
- ibex_pkg gains:
  - typedef enum logic [1:0] sleep_state_e {SLP_RUN, SLP_IDLE, SLP_SLEEP, SLP_WAKE};
  - localparams WAKE_CAUSE_NONE=0, WAKE_CAUSE_DBG=1, WAKE_CAUSE_NMI=2, WAKE_CAUSE_IRQ0=3.
- One sub-module: ibex_sat_counter (parametrised width, inc/clr, clr priority, saturate at all-ones) for sleep_cnt_o.
- Hysteresis and warm-up counters share one 8-bit register, since they are never active together.
- Elaboration assertions check the parameter ranges.

## Test plan
- Reset then idle: core_busy_i=0, sleep_allow_i=1, no irqs, IdleHyst=4 → core_sleep_o rises on the 5th edge after idle is first sampled; clk_en_o falls with it.
- Glitch: with IdleHyst=4, drop sleep_allow_i for one cycle at IDLE hcnt=2 → FSM returns to RUN and needs a further 5 cycles to reach SLEEP.
- Masked/unmasked wake: in SLEEP, irq_i[5]=1 with irq_en_i[5]=0 → stays asleep, clk_en_o=0. Then set irq_en_i[5]=1 → clk_en_o=1 in the same cycle, wake_valid_o pulses next cycle, wake_cause_o=8, RUN after WakeLat=2 further cycles.
- Priority: in SLEEP, assert debug_req_i, irq_nm_i and irq_i[0] (enabled) together → wake_cause_o=1. Repeat without debug → 2.
- Counter: sleep for 10 cycles → sleep_cnt_o=10. Assert clr during a SLEEP cycle → 0 next cycle. Preload near 32'hFFFF_FFFE and sleep 5 cycles → holds 32'hFFFF_FFFF.
- Reset in SLEEP: assert rst_i → clk_en_o=1 immediately; after the edge, state is RUN and all outputs are at reset values. test_en_i=1 in SLEEP → clk_en_o=1 while core_sleep_o stays 1.
